wb_pipe_unit: RTL and testbench

WB_PIPE_UNIT -- requirements
Module: wb_pipe_unit

---
 rtl/wb_pipe_unit.sv | 87 ++++++++
 tb/tb_wb_pipe_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/wb_pipe_unit.sv
// wb_pipe_unit: write-back stage that selects and formats result data, drives the
// register-file write port and forwarding bus, and counts retired instructions.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : MEM-side handshake (in_ready = !stall)
//   in_wb_sel             : 00 ALU, 01 MEM, 10 LINK, 11 IMM
//   in_reg_write, in_rd   : write intent and destination register
//   in_alu_result, in_mem_data, in_link, in_imm : candidate results
//   in_load_byte, in_load_signed, in_byte_hi    : half-width load formatting
//   stall, flush          : hold the stage / discard the held entry
//   rf_we, rf_waddr, rf_wdata      : register-file write port
//   fwd_valid, fwd_rd, fwd_data    : forwarding bus (ignores stall)
//   retired_count         : saturating retire counter
module wb_pipe_unit #(
   parameter int DATA_W     = 16,
   parameter int REG_ADDR_W = 3,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1:0]            in_wb_sel,
   input  logic                  in_reg_write,
   input  logic [REG_ADDR_W-1:0] in_rd,
   input  logic [DATA_W-1:0]     in_alu_result,
   input  logic [DATA_W-1:0]     in_mem_data,
   input  logic [DATA_W-1:0]     in_link,
   input  logic [DATA_W-1:0]     in_imm,
   input  logic                  in_load_byte,
   input  logic                  in_load_signed,
   input  logic                  in_byte_hi,
   input  logic                  stall,
   input  logic                  flush,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0]     rf_wdata,
   output logic                  fwd_valid,
   output logic [REG_ADDR_W-1:0] fwd_rd,
   output logic [DATA_W-1:0]     fwd_data,
   output logic [CNT_W-1:0]      retired_count
);
   localparam int H = DATA_W / 2;

   logic                  valid_q, we_q;
   logic [REG_ADDR_W-1:0] rd_q;
   logic [DATA_W-1:0]     data_q;
   logic                  accept, writes;
   logic [H-1:0]          byte_sel;
   logic [DATA_W-1:0]     byte_ext, mem_fmt, wb_data;

   assign in_ready  = !stall;
   assign accept    = in_valid && in_ready;
   assign byte_sel  = in_byte_hi ? in_mem_data[DATA_W-1:H] : in_mem_data[H-1:0];
   assign byte_ext  = {{H{in_load_signed & byte_sel[H-1]}}, byte_sel};
   assign mem_fmt   = in_load_byte ? byte_ext : in_mem_data;
   assign wb_data   = in_wb_sel == 2'b00 ? in_alu_result :
                      in_wb_sel == 2'b01 ? mem_fmt :
                      in_wb_sel == 2'b10 ? in_link : in_imm;
   // register 0 is hard-wired, so an entry targeting it never writes or forwards
   assign writes    = valid_q && we_q && (rd_q != '0);
   assign rf_we     = writes && !stall;
   assign rf_waddr  = rd_q;
   assign rf_wdata  = data_q;
   assign fwd_valid = writes;
   assign fwd_rd    = rd_q;
   assign fwd_data  = data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q       <= 1'b0;
         we_q          <= 1'b0;
         rd_q          <= '0;
         data_q        <= '0;
         retired_count <= '0;
      end else begin
         if (flush) valid_q <= 1'b0;
         else if (!stall) valid_q <= accept;
         if (accept && !flush) begin
            we_q   <= in_reg_write;
            rd_q   <= in_rd;
            data_q <= wb_data;
         end
         if (valid_q && !stall && !flush && retired_count != '1)
            retired_count <= retired_count + 1'b1;
      end
   end
endmodule

// File: tb/tb_wb_pipe_unit.sv
// tb_wb_pipe_unit: directed self-checking bench for wb_pipe_unit.
module tb_wb_pipe_unit;
   logic        clk = 1'b0, rst_n = 1'b1;
   logic        in_valid = 1'b0, in_ready, in_reg_write = 1'b0;
   logic [1:0]  in_wb_sel = 2'b00;
   logic [2:0]  in_rd = '0;
   logic [15:0] in_alu_result = '0, in_mem_data = '0, in_link = '0, in_imm = '0;
   logic        in_load_byte = 1'b0, in_load_signed = 1'b0, in_byte_hi = 1'b0;
   logic        stall = 1'b0, flush = 1'b0;
   logic        rf_we, fwd_valid, in_ready4, rf_we4, fwd_valid4;
   logic [2:0]  rf_waddr, fwd_rd, rf_waddr4, fwd_rd4;
   logic [15:0] rf_wdata, fwd_data, rf_wdata4, fwd_data4, retired_count;
   logic [3:0]  retired_count4;
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   wb_pipe_unit dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_wb_sel(in_wb_sel), .in_reg_write(in_reg_write), .in_rd(in_rd),
      .in_alu_result(in_alu_result), .in_mem_data(in_mem_data), .in_link(in_link),
      .in_imm(in_imm), .in_load_byte(in_load_byte), .in_load_signed(in_load_signed),
      .in_byte_hi(in_byte_hi), .stall(stall), .flush(flush), .rf_we(rf_we),
      .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .fwd_valid(fwd_valid),
      .fwd_rd(fwd_rd), .fwd_data(fwd_data), .retired_count(retired_count));

   wb_pipe_unit #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
      .in_wb_sel(in_wb_sel), .in_reg_write(in_reg_write), .in_rd(in_rd),
      .in_alu_result(in_alu_result), .in_mem_data(in_mem_data), .in_link(in_link),
      .in_imm(in_imm), .in_load_byte(in_load_byte), .in_load_signed(in_load_signed),
      .in_byte_hi(in_byte_hi), .stall(stall), .flush(flush), .rf_we(rf_we4),
      .rf_waddr(rf_waddr4), .rf_wdata(rf_wdata4), .fwd_valid(fwd_valid4),
      .fwd_rd(fwd_rd4), .fwd_data(fwd_data4), .retired_count(retired_count4));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] sel, input logic we, input logic [2:0] rd,
                        input logic [15:0] d, input logic lb, input logic ls, input logic bh);
      in_valid = 1'b1; in_wb_sel = sel; in_reg_write = we; in_rd = rd;
      in_alu_result = sel == 2'b00 ? d : 16'hDEAD;
      in_mem_data   = sel == 2'b01 ? d : 16'hBEEF;
      in_link       = sel == 2'b10 ? d : 16'hCAFE;
      in_imm        = sel == 2'b11 ? d : 16'hF00D;
      in_load_byte = lb; in_load_signed = ls; in_byte_hi = bh;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got %0b exp 0", rf_we); end
      checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL reset_fwd_valid got %0b exp 0", fwd_valid); end
      checks++; if (rf_waddr !== 3'd0) begin errors++; $display("FAIL reset_waddr got %0h exp 0", rf_waddr); end
      checks++; if (rf_wdata !== 16'h0) begin errors++; $display("FAIL reset_wdata got %0h exp 0", rf_wdata); end
      checks++; if (retired_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", retired_count); end
      stall = 1'b1; #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_stall got %0b exp 0", in_ready); end
      stall = 1'b0; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", in_ready); end
      step(); step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_alu();
      drive(2'b00, 1'b1, 3'd3, 16'h1234, 1'b0, 1'b0, 1'b0);
      step();
      in_valid = 1'b0; #1;
      checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL alu_we got %0b exp 1", rf_we); end
      checks++; if (rf_waddr !== 3'd3) begin errors++; $display("FAIL alu_waddr got %0d exp 3", rf_waddr); end
      checks++; if (rf_wdata !== 16'h1234) begin errors++; $display("FAIL alu_wdata got %0h exp 1234", rf_wdata); end
      checks++; if (fwd_valid !== 1'b1 || fwd_rd !== 3'd3) begin errors++; $display("FAIL alu_fwd got %0b/%0d exp 1/3", fwd_valid, fwd_rd); end
      step();
      checks++; if (retired_count !== 16'd1) begin errors++; $display("FAIL alu_count got %0d exp 1", retired_count); end
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL alu_bubble_we got %0b exp 0", rf_we); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_d [6];
      exp_d = '{16'hFF80, 16'h00F1, 16'h0080, 16'hFFF1, 16'h80F1, 16'hABCD};
      drive(2'b01, 1'b1, 3'd1, 16'h80F1, 1'b1, 1'b1, 1'b1); step();
      checks++; if (rf_wdata !== exp_d[0] || rf_we !== 1'b1) begin errors++; $display("FAIL byte_hi_signed got %0h/%0b exp %0h/1", rf_wdata, rf_we, exp_d[0]); end
      drive(2'b01, 1'b1, 3'd1, 16'h80F1, 1'b1, 1'b0, 1'b0); step();
      checks++; if (rf_wdata !== exp_d[1] || rf_we !== 1'b1) begin errors++; $display("FAIL byte_lo_unsigned got %0h/%0b exp %0h/1", rf_wdata, rf_we, exp_d[1]); end
      drive(2'b01, 1'b1, 3'd1, 16'h80F1, 1'b1, 1'b0, 1'b1); step();
      checks++; if (rf_wdata !== exp_d[2]) begin errors++; $display("FAIL byte_hi_unsigned got %0h exp %0h", rf_wdata, exp_d[2]); end
      drive(2'b01, 1'b1, 3'd1, 16'h80F1, 1'b1, 1'b1, 1'b0); step();
      checks++; if (rf_wdata !== exp_d[3]) begin errors++; $display("FAIL byte_lo_signed got %0h exp %0h", rf_wdata, exp_d[3]); end
      drive(2'b01, 1'b1, 3'd1, 16'h80F1, 1'b0, 1'b1, 1'b1); step();
      checks++; if (rf_wdata !== exp_d[4]) begin errors++; $display("FAIL mem_word got %0h exp %0h", rf_wdata, exp_d[4]); end
      drive(2'b11, 1'b1, 3'd7, 16'hABCD, 1'b0, 1'b0, 1'b0); step();
      checks++; if (rf_wdata !== exp_d[5] || rf_waddr !== 3'd7) begin errors++; $display("FAIL imm got %0h/%0d exp %0h/7", rf_wdata, rf_waddr, exp_d[5]); end
      in_valid = 1'b0; step();
      checks++; if (retired_count !== 16'd7) begin errors++; $display("FAIL b2b_count got %0d exp 7", retired_count); end
   endtask

   task automatic test_stall();
      drive(2'b10, 1'b1, 3'd5, 16'h0042, 1'b0, 1'b0, 1'b0); step();
      drive(2'b00, 1'b1, 3'd6, 16'h9999, 1'b0, 1'b0, 1'b0);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (rf_we !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL stall_we cyc %0d got we=%0b rdy=%0b exp 0/0", i, rf_we, in_ready); end
         checks++; if (fwd_valid !== 1'b1 || fwd_data !== 16'h0042 || fwd_rd !== 3'd5) begin errors++; $display("FAIL stall_fwd cyc %0d got %0b/%0h/%0d exp 1/42/5", i, fwd_valid, fwd_data, fwd_rd); end
         checks++; if (retired_count !== 16'd7) begin errors++; $display("FAIL stall_count cyc %0d got %0d exp 7", i, retired_count); end
         step();
      end
      stall = 1'b0; in_valid = 1'b0; #1;
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 3'd5 || rf_wdata !== 16'h0042) begin errors++; $display("FAIL stall_release got %0b/%0d/%0h exp 1/5/42", rf_we, rf_waddr, rf_wdata); end
      step();
      checks++; if (retired_count !== 16'd8 || rf_we !== 1'b0) begin errors++; $display("FAIL stall_retire got %0d/%0b exp 8/0", retired_count, rf_we); end
   endtask

   task automatic test_flush();
      drive(2'b00, 1'b1, 3'd2, 16'h5555, 1'b0, 1'b0, 1'b0); step();
      in_valid = 1'b0; stall = 1'b1; step();
      flush = 1'b1; step();
      flush = 1'b0; stall = 1'b0; #1;
      checks++; if (fwd_valid !== 1'b0 || rf_we !== 1'b0) begin errors++; $display("FAIL flush_held got %0b/%0b exp 0/0", fwd_valid, rf_we); end
      drive(2'b00, 1'b1, 3'd4, 16'h7777, 1'b0, 1'b0, 1'b0); flush = 1'b1; step();
      flush = 1'b0; in_valid = 1'b0; #1;
      checks++; if (fwd_valid !== 1'b0) begin errors++; $display("FAIL flush_over_capture got %0b exp 0", fwd_valid); end
      step();
      checks++; if (retired_count !== 16'd8) begin errors++; $display("FAIL flush_count got %0d exp 8", retired_count); end
   endtask

   task automatic test_r0();
      drive(2'b00, 1'b1, 3'd0, 16'h0077, 1'b0, 1'b0, 1'b0); step();
      in_valid = 1'b0; #1;
      checks++; if (rf_we !== 1'b0 || fwd_valid !== 1'b0) begin errors++; $display("FAIL r0_write got %0b/%0b exp 0/0", rf_we, fwd_valid); end
      step();
      checks++; if (retired_count !== 16'd9) begin errors++; $display("FAIL r0_count got %0d exp 9", retired_count); end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 20; i++) begin
         drive(2'b00, 1'b1, 3'd1, 16'(i), 1'b0, 1'b0, 1'b0); step();
      end
      in_valid = 1'b0; step();
      checks++; if (retired_count4 !== 4'd15) begin errors++; $display("FAIL sat_count4 got %0d exp 15", retired_count4); end
      checks++; if (retired_count !== 16'd29) begin errors++; $display("FAIL sat_count16 got %0d exp 29", retired_count); end
   endtask

   task automatic test_async_reset();
      drive(2'b00, 1'b1, 3'd4, 16'h0BAD, 1'b0, 1'b0, 1'b0); step();
      rst_n = 1'b0; #1;
      checks++; if (rf_we !== 1'b0 || fwd_valid !== 1'b0) begin errors++; $display("FAIL async_we got %0b/%0b exp 0/0", rf_we, fwd_valid); end
      checks++; if (rf_waddr !== 3'd0 || rf_wdata !== 16'h0) begin errors++; $display("FAIL async_data got %0d/%0h exp 0/0", rf_waddr, rf_wdata); end
      checks++; if (retired_count !== 16'd0 || retired_count4 !== 4'd0) begin errors++; $display("FAIL async_count got %0d/%0d exp 0/0", retired_count, retired_count4); end
      drive(2'b00, 1'b1, 3'd6, 16'h0099, 1'b0, 1'b0, 1'b0);
      @(negedge clk); rst_n = 1'b1;
      step();
      in_valid = 1'b0; #1;
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 3'd6 || rf_wdata !== 16'h0099) begin errors++; $display("FAIL post_reset_capture got %0b/%0d/%0h exp 1/6/99", rf_we, rf_waddr, rf_wdata); end
      step();
      checks++; if (retired_count !== 16'd1) begin errors++; $display("FAIL post_reset_count got %0d exp 1", retired_count); end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_back_to_back();
      test_stall();
      test_flush();
      test_r0();
      test_saturation();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
